// File: rtl/fd_pkg.sv
// fd_pkg: shared types and default geometry for the face-detect frame scanner.
package fd_pkg;

  // Default frame geometry (pixels)
  localparam int FD_IMG_W = 160;
  localparam int FD_IMG_H = 120;
  localparam int FD_WIN   = 24;
  localparam int FD_STEP  = 4;

  // Scan controller states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_REPORT  = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } scan_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_pos_gen.sv
// scan_pos_gen: raster-order window position generator.
// Steps the window corner across the frame in STEP increments and flags the
// last window. Comparisons use 9-bit sums so a corner near 255 cannot wrap.
module scan_pos_gen #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int WIN   = 24,
  parameter int STEP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [7:0] win_x,
  output logic [7:0] win_y,
  output logic       last
);

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] XLIM9 = 9'(IMG_W - WIN);
  localparam logic [8:0] YLIM9 = 9'(IMG_H - WIN);

  logic [7:0] win_x_r;
  logic [7:0] win_y_r;
  logic [8:0] nx_s;
  logic [8:0] ny_s;
  logic       x_fit_s;
  logic       y_fit_s;

  // Candidate next corner and whether it still fits inside the frame
  always_comb begin
    nx_s    = {1'b0, win_x_r} + STEP9;
    ny_s    = {1'b0, win_y_r} + STEP9;
    x_fit_s = (nx_s <= XLIM9);
    y_fit_s = (ny_s <= YLIM9);
  end

  // Corner registers: cleared at scan start, stepped on each advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x_r <= 8'd0;
      win_y_r <= 8'd0;
    end else if (clr) begin
      win_x_r <= 8'd0;
      win_y_r <= 8'd0;
    end else if (adv) begin
      if (x_fit_s) begin
        win_x_r <= nx_s[7:0];
      end else begin
        win_x_r <= 8'd0;
        if (y_fit_s) begin
          win_y_r <= ny_s[7:0];
        end else begin
          win_y_r <= win_y_r;
        end
      end
    end else begin
      win_x_r <= win_x_r;
      win_y_r <= win_y_r;
    end
  end

  assign win_x = win_x_r;
  assign win_y = win_y_r;
  assign last  = ~x_fit_s & ~y_fit_s;

endmodule

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: sliding-window scan controller for a face classifier.
// Launches the classifier on every window of a frame, forwards hits as
// valid/ready detection records and counts them (saturating).
// Optional macro FD_SCAN_CYCLE_CNT_EN adds a 32-bit busy-cycle counter
// output scan_cycles.
module frame_scan_ctrl
  import fd_pkg::*;
#(
  parameter int IMG_W = FD_IMG_W,
  parameter int IMG_H = FD_IMG_H,
  parameter int WIN   = FD_WIN,
  parameter int STEP  = FD_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  win_x,
  output logic [7:0]  win_y,
  output logic        cls_start,
  input  logic        cls_ready,
  input  logic        cls_done,
  input  logic        cls_hit,
  output logic        det_valid,
  input  logic        det_ready,
  output logic [7:0]  det_x,
  output logic [7:0]  det_y,
`ifdef FD_SCAN_CYCLE_CNT_EN
  output logic [31:0] scan_cycles,
`endif
  output logic [15:0] det_count
);

  scan_state_t state_r;
  logic        busy_r;
  logic        done_r;
  logic        det_valid_r;
  logic [7:0]  det_x_r;
  logic [7:0]  det_y_r;
  logic [15:0] det_count_r;
  logic        clr_s;
  logic        adv_s;
  logic        last_s;
  logic [7:0]  win_x_s;
  logic [7:0]  win_y_s;

  // A start is only honoured from IDLE
  assign clr_s = (state_r == S_IDLE) & start;
  assign adv_s = (state_r == S_ADVANCE);

  scan_pos_gen #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .WIN  (WIN),
    .STEP (STEP)
  ) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .adv  (adv_s),
    .win_x(win_x_s),
    .win_y(win_y_s),
    .last (last_s)
  );

  // Scan sequencing FSM with its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      det_valid_r <= 1'b0;
      det_x_r     <= 8'd0;
      det_y_r     <= 8'd0;
      det_count_r <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= S_ISSUE;
            busy_r      <= 1'b1;
            det_count_r <= 16'd0;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (cls_ready) begin
            state_r <= S_WAIT;
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (cls_done) begin
            if (cls_hit) begin
              state_r     <= S_REPORT;
              det_valid_r <= 1'b1;
              det_x_r     <= win_x_s;
              det_y_r     <= win_y_s;
              det_count_r <= sat_inc16(det_count_r);
            end else begin
              state_r <= S_ADVANCE;
            end
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_REPORT: begin
          if (det_ready) begin
            state_r     <= S_ADVANCE;
            det_valid_r <= 1'b0;
          end else begin
            state_r <= S_REPORT;
          end
        end
        S_ADVANCE: begin
          if (last_s) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          det_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FD_SCAN_CYCLE_CNT_EN
  logic [31:0] scan_cycles_r;

  // Busy-cycle counter: cleared on accepted start, frozen once idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cycles_r <= 32'd0;
    end else if (clr_s) begin
      scan_cycles_r <= 32'd0;
    end else if (busy_r) begin
      scan_cycles_r <= scan_cycles_r + 32'd1;
    end else begin
      scan_cycles_r <= scan_cycles_r;
    end
  end

  assign scan_cycles = scan_cycles_r;
`endif

  // cls_start must coincide with the cycle cls_ready is seen in ISSUE
  assign cls_start = (state_r == S_ISSUE) & cls_ready;
  assign busy      = busy_r;
  assign done      = done_r;
  assign win_x     = win_x_s;
  assign win_y     = win_y_s;
  assign det_valid = det_valid_r;
  assign det_x     = det_x_r;
  assign det_y     = det_y_r;
  assign det_count = det_count_r;

endmodule
